// File: rtl/counter_snapshot_pkg.sv
// Shared types and constants for the counter snapshot buffer.
package counter_snapshot_pkg;

  localparam int CNT_W         = 8;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [CNT_W-1:0] wrap;
    logic [CNT_W-1:0] value;
  } snap_t;

endpackage

// File: rtl/snap_fifo.sv
// Small synchronous FIFO for snapshot entries: storage, pointers, occupancy and full/empty.
// When empty, rdata keeps presenting the last entry that was popped (zero after reset).
module snap_fifo
  import counter_snapshot_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEFAULT,
  parameter type data_t = snap_t,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  data_t            wdata,
  output data_t            rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  data_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  data_t            hold_q, hold_d;
  logic             push_acc, pop_acc;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    empty    = (level_q == '0);
    push_acc = push && !full;
    pop_acc  = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    level_d = level_q + LVL_W'(push_acc) - LVL_W'(pop_acc);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only read while level says they are valid.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = empty ? hold_q : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/counter_snapshot_buffer.sv
// Tracks wraps of an upstream counter and queues {wrap_count, counter} snapshots for a reader.
// Optional macro COUNTER_SNAPSHOT_AUTO_WRAP_EN: every detected wrap also enqueues a snapshot.
module counter_snapshot_buffer
  import counter_snapshot_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   snap_req,
  input  logic                   clear_drop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*CNT_W-1:0]     out_data,
  output logic [CNT_W-1:0]       wrap_count,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dropped
);

  logic [CNT_W-1:0] cnt_prev_q, cnt_prev_d;
  logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic             dropped_q, dropped_d;
  logic             wrap, push, pop, full, empty;
  snap_t            entry, head;

  always_comb begin
    wrap         = (cnt_in < cnt_prev_q);
    wrap_count_d = wrap_count_q + CNT_W'(wrap);
    cnt_prev_d   = cnt_in;
`ifdef COUNTER_SNAPSHOT_AUTO_WRAP_EN
    push = snap_req || wrap;
`else
    push = snap_req;
`endif
    entry       = '{wrap: wrap_count_d, value: cnt_in};
    pop         = !empty && out_ready;
    // A rejected push outranks a clear in the same cycle.
    dropped_d   = dropped_q;
    if (clear_drop) begin
      dropped_d = 1'b0;
    end
    if (push && full) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_prev_q   <= '0;
      wrap_count_q <= '0;
      dropped_q    <= 1'b0;
    end else begin
      cnt_prev_q   <= cnt_prev_d;
      wrap_count_q <= wrap_count_d;
      dropped_q    <= dropped_d;
    end
  end

  snap_fifo #(
    .DEPTH  (DEPTH),
    .data_t (snap_t)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (entry),
    .rdata   (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid  = !empty;
  assign out_data   = head;
  assign wrap_count = wrap_count_q;
  assign dropped    = dropped_q;

endmodule
